uart_rx: RTL and testbench

Asynchronous serial receiver that deserializes 8N1 frames from the board RX pin and hands each byte to the UART command decoder. It produces the `rx_data` / `rx_done` pair that the decoder consumes. It oversamples the line 16x from an internal baud tick, validates start and stop bits, and flags framing errors and line breaks.

---
 rtl/uart_rx.sv | 142 ++++++++++++++
 tb/tb_uart_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver: 16x oversampling from an internal baud tick, start-bit
// glitch rejection, framing-error detection and line-break hold-off.
module uart_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_busy,
    output logic       frame_err,
    output logic [2:0] dbg_state
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DW  = $clog2(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          rx_meta;
    logic          rx_s;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [3:0]    smp;
    logic [2:0]    bit_cnt;
    logic [7:0]    sh;
    logic          take_bit;
    logic          done_d;
    logic          ferr_d;

    // Two-stage synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Free-running baud tick; never realigned to the start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        take_bit = 1'b0;
        done_d   = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                // Mid-start-bit recheck rejects glitches shorter than half a bit.
                if (tick && smp == 4'd7) state_d = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (tick && smp == 4'd15) begin
                    take_bit = 1'b1;
                    if (bit_cnt == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick && smp == 4'd15) begin
                    if (rx_s) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            smp       <= '0;
            bit_cnt   <= '0;
            sh        <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                smp <= '0;
            end else if (tick) begin
                smp <= smp + 4'd1;
            end
            if (state_q == S_START && state_d == S_DATA) begin
                bit_cnt <= '0;
            end else if (take_bit) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (take_bit) sh <= {rx_s, sh[7:1]};
            if (done_d) rx_data <= sh;
            rx_done   <= done_d;
            frame_err <= ferr_d;
            rx_busy   <= (state_d != S_IDLE);
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV=4 (64 clk per bit): framing, reset,
// back-to-back frames, glitch rejection, framing error/break and baud skew.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;

    // Observed-side bookkeeping, written only by the monitor.
    int         done_cnt = 0;
    int         ferr_cnt = 0;
    int         bad_cnt  = 0;
    int         got_n    = 0;
    int         cur_run  = 0;
    int         last_run = 0;
    logic       prev_done = 1'b0;
    logic       prev_ferr = 1'b0;
    logic [7:0] got_mem [32];

    logic [7:0] exp_q [$];
    int         rd = 0;

    uart_rx #(
        .CLK_FREQ  (640),
        .BAUD      (10),
        .OVERSAMPLE(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .rx_busy  (rx_busy),
        .frame_err(frame_err),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt++;
            if (got_n < 32) got_mem[got_n] = rx_data;
            got_n++;
        end
        if (frame_err) ferr_cnt++;
        if ((rx_done && frame_err) || (rx_done && prev_done) || (frame_err && prev_ferr)) bad_cnt++;
        prev_done = rx_done;
        prev_ferr = frame_err;
        if (rx_busy) begin
            cur_run++;
        end else begin
            if (cur_run != 0) last_run = cur_run;
            cur_run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Full frame; the line is left at the stop-bit level afterwards.
    task automatic send_frame(input logic [7:0] b, input int bt, input logic stop_bit);
        rx = 1'b0;
        idle(bt);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(bt);
        end
        rx = stop_bit;
        idle(bt);
    endtask

    task automatic check_byte(input string tag);
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd < 32) begin
            check(tag, {24'b0, got_mem[rd]}, {24'b0, e});
        end else begin
            check(tag, 32'hdead, {24'b0, e});
        end
        rd++;
    endtask

    initial begin
        int d0;
        int f0;

        rst = 1'b0;
        rx  = 1'b1;
        idle(5);
        check("reset_rx_data", {24'b0, rx_data}, 32'h00);
        check("reset_rx_done", {31'b0, rx_done}, 32'h0);
        check("reset_rx_busy", {31'b0, rx_busy}, 32'h0);
        check("reset_frame_err", {31'b0, frame_err}, 32'h0);
        check("reset_state", {29'b0, dbg_state}, 32'h0);
        rst = 1'b1;
        idle(100);
        check("idle_busy", {31'b0, rx_busy}, 32'h0);

        // Single frame 0x7A.
        d0 = done_cnt;
        f0 = ferr_cnt;
        exp_q.push_back(8'h7A);
        send_frame(8'h7A, 64, 1'b1);
        idle(10);
        check("7a_done_count", done_cnt - d0, 1);
        check_byte("7a_data");
        check("7a_rx_data_hold", {24'b0, rx_data}, 32'h7A);
        check("7a_no_ferr", ferr_cnt - f0, 0);
        check("7a_busy_low", {31'b0, rx_busy}, 32'h0);

        // Reset in the middle of data bit 1.
        rx = 1'b0;
        idle(64);
        rx = 1'b0;
        idle(64);
        rx = 1'b1;
        idle(32);
        check("mid_busy", {31'b0, rx_busy}, 32'h1);
        check("mid_state_data", {29'b0, dbg_state}, 32'h2);
        rst = 1'b0;
        #1;
        check("mid_rst_rx_data", {24'b0, rx_data}, 32'h00);
        check("mid_rst_busy", {31'b0, rx_busy}, 32'h0);
        check("mid_rst_done", {31'b0, rx_done}, 32'h0);
        check("mid_rst_ferr", {31'b0, frame_err}, 32'h0);
        check("mid_rst_state", {29'b0, dbg_state}, 32'h0);
        idle(10);
        rst = 1'b1;
        idle(100);
        d0 = done_cnt;
        exp_q.push_back(8'h31);
        send_frame(8'h31, 64, 1'b1);
        idle(10);
        check("31_done_count", done_cnt - d0, 1);
        check_byte("31_data");

        // Back-to-back frames with no idle bits.
        d0 = done_cnt;
        exp_q.push_back(8'h61);
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h35);
        send_frame(8'h61, 64, 1'b1);
        send_frame(8'h1B, 64, 1'b1);
        send_frame(8'h35, 64, 1'b1);
        idle(10);
        check("b2b_done_count", done_cnt - d0, 3);
        check_byte("b2b_data0");
        check_byte("b2b_data1");
        check_byte("b2b_data2");

        // 20-clk low glitch on an idle line.
        idle(50);
        d0 = done_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        idle(20);
        rx = 1'b1;
        idle(100);
        check("glitch_no_done", done_cnt - d0, 0);
        check("glitch_no_ferr", ferr_cnt - f0, 0);
        check("glitch_busy_low", {31'b0, rx_busy}, 32'h0);
        check("glitch_busy_short", {31'b0, (last_run > 0 && last_run < 40)}, 32'h1);

        // Stop bit low, then a held-low line.
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'h55, 64, 1'b0);
        idle(300);
        check("brk_ferr_count", ferr_cnt - f0, 1);
        check("brk_no_done", done_cnt - d0, 0);
        check("brk_rx_data_kept", {24'b0, rx_data}, 32'h35);
        check("brk_busy_held", {31'b0, rx_busy}, 32'h1);
        check("brk_state", {29'b0, dbg_state}, 32'h4);
        rx = 1'b1;
        idle(20);
        check("brk_exit_busy", {31'b0, rx_busy}, 32'h0);
        check("brk_ferr_single", ferr_cnt - f0, 1);
        d0 = done_cnt;
        exp_q.push_back(8'h78);
        send_frame(8'h78, 64, 1'b1);
        idle(10);
        check("78_done_count", done_cnt - d0, 1);
        check_byte("78_data");

        // +/-3% baud skew: 66 and 62 clk per bit.
        d0 = done_cnt;
        f0 = ferr_cnt;
        exp_q.push_back(8'h00);
        send_frame(8'h00, 66, 1'b1);
        idle(30);
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 66, 1'b1);
        idle(30);
        exp_q.push_back(8'h00);
        send_frame(8'h00, 62, 1'b1);
        idle(30);
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 62, 1'b1);
        idle(30);
        check("skew_done_count", done_cnt - d0, 4);
        check("skew_no_ferr", ferr_cnt - f0, 0);
        check_byte("slow_00");
        check_byte("slow_ff");
        check_byte("fast_00");
        check_byte("fast_ff");

        check("pulse_rules", bad_cnt, 0);
        check("total_frames", got_n, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
